wb_arbiter: RTL
===============

// Module: wb_arbiter
// PURPOSE
//  Write-back arbiter in front of the regfile write port (we/waddr/wdata). Merges in-order MEM/WB
//  results with results from a long-latency unit (divider/multi-cycle MAC) via a small queue.
//  Pipeline write always wins the port; queued results drain in idle cycles. Exports pending-write
//  flags so ID can stall on RAW against queued results.
// PARAMETERS
//  DEPTH   4  queue entries; power of 2, >=2
//  PTR_W   2  log2(DEPTH); pointer width, count width = PTR_W+1
// PORTS
//  clk        in   1   clock; all state updates on posedge
//  rst        in   1   synchronous, active-high reset (`RstEnable)
//  pipe_we    in   1   MEM/WB write enable
//  pipe_waddr in   5   MEM/WB destination (`RegAddrBus)
//  pipe_wdata in   32  MEM/WB data (`RegBus)
//  lu_valid   in   1   long-unit result valid
//  lu_ready   out  1   arbiter accepts lu result this cycle
//  lu_waddr   in   5   long-unit destination
//  lu_wdata   in   32  long-unit data
//  we         out  1   to regfile write enable
//  waddr      out  5   to regfile write address
//  wdata      out  32  to regfile write data
//  chk_addr1  in   5   ID read address 1 (hazard query)
//  chk_addr2  in   5   ID read address 2
//  chk_pend1  out  1   chk_addr1 has a valid queued write
//  chk_pend2  out  1   chk_addr2 has a valid queued write
//  q_count    out  PTR_W+1  occupied entries, incl. squashed-not-yet-popped
// BEHAVIOUR
//  - Reset: queue emptied, all valid bits 0, q_count=0, lu_ready=1 once rst low; during rst:
//    we=0, waddr=0, wdata=`ZeroWord, chk_pend*=0, lu_ready=0.
//  - Port mux (combinational): pipe_we=1 -> we/waddr/wdata = pipe_*. Else head valid -> head entry,
//    we=1, popped this edge. Else we=0, waddr=0, wdata=`ZeroWord.
//  - Accept: lu_ready = !full. Handshake lu_valid&lu_ready. Accepted result with lu_waddr==0 or
//    (pipe_we & lu_waddr==pipe_waddr) is discarded (lu is older; pipe write supersedes); else enqueued
//    at tail with valid=1.
//  - Squash (WAW): when pipe_we=1 and pipe_waddr!=0, every queued entry with waddr==pipe_waddr has
//    valid cleared at the edge. Invalid head entries are popped every cycle regardless of pipe_we,
//    with no regfile write.
//  - Pop of valid head only when pipe_we=0. Push+pop same cycle legal (count unchanged).
//  - Full: lu_ready=0; lu must hold lu_valid/data stable until accepted. No overflow possible.
//  - Empty: no pop; we driven only by pipe. Pointers wrap modulo DEPTH.
//  - chk_pendN = (chk_addrN!=0) & any valid entry with waddr==chk_addrN. Uses current state only
//    (entry squashed/popped this cycle still reads pending).
//  - Ordering of lu results not yet presented is the issuer's job (ID stalls while lu busy).
//  - Reset mid-drain: all entries dropped, no write issued in the reset cycle.
// CONFIGURATION
//  `WBQ_BYPASS_EN defined: lu result accepted when queue empty and pipe_we=0 drives we/waddr/wdata
//   in the same cycle (not enqueued); latency 0. Undefined: every accepted lu result is enqueued;
//   earliest regfile write is the next cycle (latency >=1).
// STRUCTURE
//  - defs.v: add `WbqDepth 4, `WbqPtrW 2; reuse `RegBus, `RegAddrBus, `ZeroWord, `RstEnable,
//    `WriteEnable.
//  - One sub-module wbq_fifo: storage (waddr,wdata,valid), ptrs, count, squash-by-addr,
//    two addr-match lookups. Arbitration, accept/discard and bypass stay in wb_arbiter.
// TESTING
//  1 lu {r5,0x11} with pipe idle, queue empty -> non-bypass: we=1 r5=0x11 next cycle; bypass: same cycle.
//  2 Hold pipe_we=1 (r1..) 5 cycles, present lu r6..r10 -> 4 accepted, lu_ready=0 at q_count=4,
//    5th accepted after first pop; drain order r6..r10 after pipe idles.
//  3 Queue holds r7=0xA; pipe writes r7=0xB -> chk_pend on r7 drops next cycle; r7 never rewritten
//    with 0xA; squashed head pops with we=0.
//  4 lu_waddr=0 or lu_waddr==pipe_waddr same cycle -> handshake completes, q_count unchanged, no write.
//  5 chk_addr1=r9 with r9 queued -> chk_pend1=1; chk_addr2=0 -> chk_pend2=0.
//  6 rst=1 with q_count=3 -> next cycle q_count=0, we=0, chk_pend*=0; queued data never written.

Source files
------------

// File: rtl/wb_arbiter_pkg.sv
// Shared widths, queue sizing and entry type for the write-back arbiter.
package wb_arbiter_pkg;

  localparam int REG_W     = 32;
  localparam int ADDR_W    = 5;
  localparam int WBQ_DEPTH = 4;
  localparam int WBQ_PTR_W = 2;

  localparam logic [REG_W-1:0]  ZERO_WORD = '0;
  localparam logic [ADDR_W-1:0] ZERO_ADDR = '0;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [REG_W-1:0]  data;
  } wb_req_t;

  // r0 is hardwired, so it never counts as a pending destination.
  function automatic logic addr_hit(input logic [ADDR_W-1:0] query, input logic [ADDR_W-1:0] entry);
    return (query != ZERO_ADDR) && (query == entry);
  endfunction

endpackage

// File: rtl/wb_arbiter_wbq_fifo.sv
// Long-unit result queue: entry storage with per-entry valid bits, address
// squash on a newer pipeline write, and two pending-write lookups.
module wbq_fifo
  import wb_arbiter_pkg::*;
#(
  parameter int DEPTH = WBQ_DEPTH,
  parameter int PTR_W = WBQ_PTR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push_i,
  input  wb_req_t           push_req_i,
  input  logic              pop_i,
  input  logic              squash_en_i,
  input  logic [ADDR_W-1:0] squash_addr_i,
  input  logic [ADDR_W-1:0] chk_addr1_i,
  input  logic [ADDR_W-1:0] chk_addr2_i,
  output logic              head_valid_o,
  output wb_req_t           head_req_o,
  output logic              empty_o,
  output logic              full_o,
  output logic              pend1_o,
  output logic              pend2_o,
  output logic [PTR_W:0]    count_o
);

  wb_req_t           entry_q [DEPTH];
  logic [DEPTH-1:0]  valid_q, valid_d;
  logic [DEPTH-1:0]  hit1, hit2;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0]    count_q, count_d;

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_entry
      // A freshly pushed slot is never squashed: the arbiter drops any lu
      // result whose destination matches the concurrent pipeline write.
      assign valid_d[gi] = (push_i && (wr_ptr_q == PTR_W'(gi))) ||
                           (valid_q[gi] &&
                            !(pop_i && (rd_ptr_q == PTR_W'(gi))) &&
                            !(squash_en_i && (entry_q[gi].addr == squash_addr_i)));
      assign hit1[gi] = valid_q[gi] && addr_hit(chk_addr1_i, entry_q[gi].addr);
      assign hit2[gi] = valid_q[gi] && addr_hit(chk_addr2_i, entry_q[gi].addr);
    end
  endgenerate

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (push_i) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop_i)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({push_i, pop_i})
      2'b10:   count_d = count_q + (PTR_W+1)'(1);
      2'b01:   count_d = count_q - (PTR_W+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q  <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      valid_q  <= valid_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Payload needs no reset; stale slots are masked by their valid bit.
  always_ff @(posedge clk) begin
    if (push_i) entry_q[wr_ptr_q] <= push_req_i;
  end

  assign head_valid_o = valid_q[rd_ptr_q];
  assign head_req_o   = entry_q[rd_ptr_q];
  assign empty_o      = (count_q == '0);
  assign full_o       = (count_q == (PTR_W+1)'(DEPTH));
  assign pend1_o      = |hit1;
  assign pend2_o      = |hit2;
  assign count_o      = count_q;

endmodule

// File: rtl/wb_arbiter.sv
// Regfile write-port arbiter: pipeline writes win, queued long-unit results
// drain in idle cycles. Define WBQ_BYPASS_EN for zero-latency lu pass-through.
module wb_arbiter
  import wb_arbiter_pkg::*;
#(
  parameter int DEPTH = WBQ_DEPTH,
  parameter int PTR_W = WBQ_PTR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pipe_we,
  input  logic [ADDR_W-1:0] pipe_waddr,
  input  logic [REG_W-1:0]  pipe_wdata,
  input  logic              lu_valid,
  output logic              lu_ready,
  input  logic [ADDR_W-1:0] lu_waddr,
  input  logic [REG_W-1:0]  lu_wdata,
  output logic              we,
  output logic [ADDR_W-1:0] waddr,
  output logic [REG_W-1:0]  wdata,
  input  logic [ADDR_W-1:0] chk_addr1,
  input  logic [ADDR_W-1:0] chk_addr2,
  output logic              chk_pend1,
  output logic              chk_pend2,
  output logic [PTR_W:0]    q_count
);

  logic    q_head_valid, q_empty, q_full, q_pend1, q_pend2;
  wb_req_t q_head;
  logic    lu_acc, lu_drop, bypass, push, pop, squash_en;

  assign lu_ready = !rst && !q_full;
  assign lu_acc   = lu_valid && lu_ready;
  // The lu result is older than anything in MEM/WB, so a same-register pipe write supersedes it.
  assign lu_drop  = (lu_waddr == ZERO_ADDR) || (pipe_we && (lu_waddr == pipe_waddr));

`ifdef WBQ_BYPASS_EN
  assign bypass = lu_acc && !lu_drop && q_empty && !pipe_we;
`else
  assign bypass = 1'b0;
`endif

  assign push      = lu_acc && !lu_drop && !bypass;
  // Squashed heads leave silently even while the pipe owns the port.
  assign pop       = !rst && !q_empty && (!q_head_valid || !pipe_we);
  assign squash_en = !rst && pipe_we && (pipe_waddr != ZERO_ADDR);

  wbq_fifo #(
    .DEPTH (DEPTH),
    .PTR_W (PTR_W)
  ) u_wbq_fifo (
    .clk           (clk),
    .rst           (rst),
    .push_i        (push),
    .push_req_i    ('{addr: lu_waddr, data: lu_wdata}),
    .pop_i         (pop),
    .squash_en_i   (squash_en),
    .squash_addr_i (pipe_waddr),
    .chk_addr1_i   (chk_addr1),
    .chk_addr2_i   (chk_addr2),
    .head_valid_o  (q_head_valid),
    .head_req_o    (q_head),
    .empty_o       (q_empty),
    .full_o        (q_full),
    .pend1_o       (q_pend1),
    .pend2_o       (q_pend2),
    .count_o       (q_count)
  );

  always_comb begin
    we    = 1'b0;
    waddr = ZERO_ADDR;
    wdata = ZERO_WORD;
    if (!rst) begin
      if (pipe_we) begin
        we    = 1'b1;
        waddr = pipe_waddr;
        wdata = pipe_wdata;
      end else if (bypass) begin
        we    = 1'b1;
        waddr = lu_waddr;
        wdata = lu_wdata;
      end else if (!q_empty && q_head_valid) begin
        we    = 1'b1;
        waddr = q_head.addr;
        wdata = q_head.data;
      end
    end
  end

  assign chk_pend1 = !rst && q_pend1;
  assign chk_pend2 = !rst && q_pend2;

endmodule
